// File: rtl/reg_file_mp_sb.sv
// Multi-port integer register file with a per-register busy scoreboard.
// Reads are combinational with optional same-cycle bypass of writeback data.
module reg_file_mp_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_pend,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*AW-1:0]     wr_addr,
  input  logic [NWR*XLEN-1:0]   wr_data,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_addr,
  output logic [NREGS-1:0]      busy_vec,
  output logic [AW:0]           busy_cnt
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d, wr_hit;
  logic [AW:0]      busy_cnt_q, busy_cnt_d;

  // Later write ports overwrite earlier ones, giving the higher index priority.
  always_comb begin
    regs_d = regs_q;
    wr_hit = '0;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) begin
        wr_hit[wr_addr[j*AW +: AW]]  = 1'b1;
        regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
      end
    end
    regs_d[0] = '0;

    // Issue is applied after the clear so a new producer supersedes a retiring one.
    busy_d = busy_q & ~wr_hit;
    if (iss_en) busy_d[iss_addr] = 1'b1;
    busy_d[0] = 1'b0;

    busy_cnt_d = '0;
    for (int r = 0; r < NREGS; r++) begin
      busy_cnt_d = busy_cnt_d + (AW+1)'(busy_d[r]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rv;
    logic            hit;
    rd_data = '0;
    rd_pend = '0;
    ra      = '0;
    rv      = '0;
    hit     = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      ra  = rd_addr[k*AW +: AW];
      rv  = regs_q[ra];
      hit = 1'b0;
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && wr_addr[j*AW +: AW] == ra) begin
            rv  = wr_data[j*XLEN +: XLEN];
            hit = 1'b1;
          end
        end
      end
      // Outputs are forced quiet while reset is held, even if write strobes toggle.
      if (ra == '0 || !rst_n) begin
        rd_data[k*XLEN +: XLEN] = '0;
        rd_pend[k]              = 1'b0;
      end else begin
        rd_data[k*XLEN +: XLEN] = rv;
        rd_pend[k]              = busy_q[ra] && !hit;
      end
    end
  end

  assign busy_vec = busy_q;
  assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_reg_file_mp_sb.sv
// Randomized and directed bench for reg_file_mp_sb against an array-based reference model.
module tb_reg_file_mp_sb;
  localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, BYP = 1, AW = 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [AW-1:0]       ra [NRD];
  logic [NWR-1:0]      wen;
  logic [AW-1:0]       wa [NWR];
  logic [XLEN-1:0]     wd [NWR];
  logic                iss;
  logic [AW-1:0]       ia;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_pend;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NREGS-1:0]    busy_vec;
  logic [AW:0]         busy_cnt;

  assign rd_addr = {ra[1], ra[0]};
  assign wr_addr = {wa[1], wa[0]};
  assign wr_data = {wd[1], wd[0]};

  reg_file_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(BYP)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
    .wr_en(wen), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss), .iss_addr(ia),
    .busy_vec(busy_vec), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  logic [XLEN-1:0]  m_regs [NREGS];
  logic [NREGS-1:0] m_busy;
  int n_chk = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
    m_busy = '0;
  endtask

  // Expected read result: last enabled write to the address wins when bypassing.
  task automatic check_comb();
    for (int k = 0; k < NRD; k++) begin
      int a = int'(ra[k]);
      logic [XLEN-1:0] ev = m_regs[a];
      bit hit = 0;
      for (int j = 0; j < NWR; j++)
        if (BYP == 1 && wen[j] && int'(wa[j]) == a) begin ev = wd[j]; hit = 1; end
      if (a == 0) begin ev = '0; hit = 1; end
      check_eq($sformatf("rd_data[%0d]", k), 64'(rd_data[k*XLEN +: XLEN]), 64'(ev));
      check_eq($sformatf("rd_pend[%0d]", k), 64'(rd_pend[k]), 64'(m_busy[a] && !hit));
    end
  endtask

  task automatic model_edge();
    for (int j = 0; j < NWR; j++)
      if (wen[j]) begin
        if (wa[j] != 0) m_regs[wa[j]] = wd[j];
        m_busy[wa[j]] = 1'b0;
      end
    if (iss && ia != 0) m_busy[ia] = 1'b1;
  endtask

  task automatic check_seq();
    check_eq("busy_vec", 64'(busy_vec), 64'(m_busy));
    check_eq("busy_cnt", 64'(busy_cnt), 64'($countones(m_busy)));
  endtask

  task automatic do_cycle();
    #1 check_comb();
    @(posedge clk);
    model_edge();
    #1 check_seq();
    @(negedge clk);
  endtask

  task automatic idle();
    wen = '0; iss = 1'b0; ia = '0;
    for (int j = 0; j < NWR; j++) begin wa[j] = '0; wd[j] = '0; end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return ($urandom % 3 == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NREGS-1));
  endfunction

  task automatic rand_cycle();
    for (int k = 0; k < NRD; k++) ra[k] = rand_addr();
    for (int j = 0; j < NWR; j++) begin
      wen[j] = ($urandom % 3 == 0);
      wa[j]  = rand_addr();
      wd[j]  = $urandom;
    end
    iss = ($urandom % 2 == 0);
    ia  = rand_addr();
    do_cycle();
  endtask

  initial begin
    idle();
    ra[0] = 5'd5; ra[1] = 5'd0;
    model_reset();
    #2 check_eq("reset_cnt", 64'(busy_cnt), 64'd0);
    check_eq("reset_vec", 64'(busy_vec), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // basic write / read and register 0
    wen = 2'b01; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF;
    do_cycle();
    idle(); ra[0] = 5'd5; ra[1] = 5'd5;
    #1 check_eq("basic_rd0", 64'(rd_data[31:0]), 64'hDEADBEEF);
    check_eq("basic_rd1", 64'(rd_data[63:32]), 64'hDEADBEEF);
    wen = 2'b01; wa[0] = 5'd0; wd[0] = 32'h1234;
    do_cycle();
    idle(); ra[0] = 5'd0;
    #1 check_eq("reg0_rd", 64'(rd_data[31:0]), 64'd0);

    // write collision on addr 7
    ra[0] = 5'd7; ra[1] = 5'd7;
    wen = 2'b11; wa[0] = 5'd7; wa[1] = 5'd7; wd[0] = 32'h11111111; wd[1] = 32'h22222222;
    #1 check_eq("coll_bypass", 64'(rd_data[31:0]), (BYP == 1) ? 64'h22222222 : 64'd0);
    do_cycle();
    idle();
    #1 check_eq("coll_store", 64'(rd_data[31:0]), 64'h22222222);

    // scoreboard set and clear
    iss = 1'b1; ia = 5'd9;
    do_cycle();
    idle(); ra[0] = 5'd9;
    #1 check_eq("sb_busy9", 64'(busy_vec[9]), 64'd1);
    check_eq("sb_cnt1", 64'(busy_cnt), 64'd1);
    check_eq("sb_pend", 64'(rd_pend[0]), 64'd1);
    wen = 2'b01; wa[0] = 5'd9; wd[0] = 32'hA5;
    #1 check_eq("sb_wr_pend", 64'(rd_pend[0]), 64'd0);
    check_eq("sb_wr_data", 64'(rd_data[31:0]), 64'hA5);
    do_cycle();
    idle();
    #1 check_eq("sb_clr9", 64'(busy_vec[9]), 64'd0);
    check_eq("sb_cnt0", 64'(busy_cnt), 64'd0);

    // set/clear race on register 3
    iss = 1'b1; ia = 5'd3;
    do_cycle();
    iss = 1'b1; ia = 5'd3; wen = 2'b01; wa[0] = 5'd3; wd[0] = 32'h77;
    do_cycle();
    idle(); ra[0] = 5'd3;
    #1 check_eq("race_busy3", 64'(busy_vec[3]), 64'd1);
    check_eq("race_cnt", 64'(busy_cnt), 64'd1);
    check_eq("race_data", 64'(rd_data[31:0]), 64'h77);
    wen = 2'b10; wa[1] = 5'd3; wd[1] = 32'h78;
    do_cycle();
    idle();

    // saturation
    for (int r = 1; r < NREGS; r++) begin iss = 1'b1; ia = AW'(r); do_cycle(); end
    idle();
    #1 check_eq("sat_full", 64'(busy_cnt), 64'(NREGS-1));
    iss = 1'b1; ia = 5'd0;
    do_cycle();
    idle();
    #1 check_eq("sat_reg0", 64'(busy_cnt), 64'(NREGS-1));
    for (int r = 1; r < NREGS; r += 2) begin
      wen = 2'b11; wa[0] = AW'(r); wa[1] = (r + 1 < NREGS) ? AW'(r + 1) : AW'(r);
      wd[0] = $urandom; wd[1] = $urandom;
      do_cycle();
    end
    idle();
    #1 check_eq("sat_empty", 64'(busy_cnt), 64'd0);

    for (int i = 0; i < 1500; i++) rand_cycle();

    // asynchronous reset mid-operation, with writes and issue active
    wen = 2'b11; wa[0] = 5'd12; wa[1] = 5'd13; wd[0] = 32'hCAFE; wd[1] = 32'hF00D;
    iss = 1'b1; ia = 5'd14; ra[0] = 5'd12; ra[1] = 5'd13;
    rst_n = 1'b0;
    model_reset();
    #1 check_eq("arst_rd0", 64'(rd_data[31:0]), 64'd0);
    check_eq("arst_rd1", 64'(rd_data[63:32]), 64'd0);
    check_eq("arst_pend", 64'(rd_pend), 64'd0);
    check_eq("arst_vec", 64'(busy_vec), 64'd0);
    check_eq("arst_cnt", 64'(busy_cnt), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; idle();
    for (int a = 0; a < NREGS; a += 2) begin
      ra[0] = AW'(a); ra[1] = AW'(a + 1);
      do_cycle();
    end

    for (int i = 0; i < 1500; i++) rand_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
